iq_frame_rx: RTL

Serial receiver for the 32-bit I/Q LVDS frame stream that the modem's `lvds_trx` path emits on `tx_a`/`clk_a`. It oversamples the serial clock and data with the system clock, aligns to the frame sync bits, and presents each 13-bit I/Q sample pair as a one-cycle strobe. It also flags the end-of-message frame and tracks framing errors. It sits on the loopback/monitor side of the modem, for board self-test and bench capture of the transmit path.

---
 rtl/iq_frame_rx.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/iq_frame_rx.sv
// iq_frame_rx: oversampling receiver for the 32-bit serial I/Q frame stream.
// Optional feature macro: IQ_FRAME_RX_ERRCNT_EN enables the saturating frame_err_cnt.
module iq_frame_rx #(
  parameter int LOCK_FRAMES = 2,
  parameter int LOSS_FRAMES = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_clk,
  input  logic        rx_data,
  output logic [12:0] i_data,
  output logic [12:0] q_data,
  output logic        valid,
  output logic        msg_end,
  output logic        locked,
  output logic [7:0]  frame_err_cnt
);

  typedef enum logic [1:0] {ST_HUNT, ST_CHECK, ST_LOCKED} state_t;
  typedef enum logic [1:0] {W_DATA, W_END, W_IDLE, W_BAD} word_t;

  localparam logic [31:0] END_WORD = {2'b10, 14'b0, 2'b01, 14'b0};
  localparam int GW = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES + 1) : 1;
  localparam int LW = (LOSS_FRAMES > 1) ? $clog2(LOSS_FRAMES + 1) : 1;

  function automatic word_t classify(input logic [31:0] w);
    if (w == END_WORD) return W_END;
    if (w == 32'b0) return W_IDLE;
    if (w[31:30] == 2'b10 && w[16] && w[15:14] == 2'b01 && !w[0]) return W_DATA;
    return W_BAD;
  endfunction

  logic          rx_clk_meta_q,  rx_clk_meta_d;
  logic          rx_clk_sync_q,  rx_clk_sync_d;
  logic          rx_clk_dly_q,   rx_clk_dly_d;
  logic          rx_data_meta_q, rx_data_meta_d;
  logic          rx_data_sync_q, rx_data_sync_d;
  logic          bit_edge_q,     bit_edge_d;
  logic [31:0]   sr_q,           sr_d;
  logic [4:0]    bit_cnt_q,      bit_cnt_d;
  state_t        state_q,        state_d;
  logic [GW-1:0] good_cnt_q,     good_cnt_d;
  logic [LW-1:0] bad_cnt_q,      bad_cnt_d;
  logic [12:0]   i_q,            i_d;
  logic [12:0]   q_q,            q_d;
  logic          valid_q,        valid_d;
  logic          msg_end_q,      msg_end_d;
  logic          locked_q,       locked_d;

  word_t word_cls;
  logic  word_wrap;
  logic  emit;

  assign word_cls  = classify(sr_q);
  assign word_wrap = (bit_cnt_q == 5'd31);

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    rx_clk_meta_d  = rx_clk;
    rx_clk_sync_d  = rx_clk_meta_q;
    rx_clk_dly_d   = rx_clk_sync_q;
    rx_data_meta_d = rx_data;
    rx_data_sync_d = rx_data_meta_q;
    bit_edge_d     = rx_clk_sync_q & ~rx_clk_dly_q;
    sr_d           = bit_edge_d ? {sr_q[30:0], rx_data_sync_q} : sr_q;
    bit_cnt_d      = bit_cnt_q;
    state_d        = state_q;
    good_cnt_d     = good_cnt_q;
    bad_cnt_d      = bad_cnt_q;
    i_d            = i_q;
    q_d            = q_q;
    valid_d        = 1'b0;
    msg_end_d      = 1'b0;
    locked_d       = locked_q;
    emit           = 1'b0;

    // The FSM looks at sr_q one cycle after it shifted, flagged by bit_edge_q.
    if (bit_edge_q) begin
      bit_cnt_d = bit_cnt_q + 5'd1;
      unique case (state_q)
        ST_HUNT: begin
          if (word_cls == W_DATA || word_cls == W_END) begin
            bit_cnt_d  = '0;
            good_cnt_d = '0;
            state_d    = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (word_wrap) begin
            if (word_cls == W_BAD) begin
              state_d = ST_HUNT;
            end else if (good_cnt_q == GW'(LOCK_FRAMES - 1)) begin
              state_d   = ST_LOCKED;
              locked_d  = 1'b1;
              bad_cnt_d = '0;
              emit      = 1'b1;
            end else begin
              good_cnt_d = good_cnt_q + GW'(1);
            end
          end
        end
        ST_LOCKED: begin
          if (word_wrap) begin
            if (word_cls == W_BAD) begin
              if (bad_cnt_q == LW'(LOSS_FRAMES - 1)) begin
                state_d  = ST_HUNT;
                locked_d = 1'b0;
              end else begin
                bad_cnt_d = bad_cnt_q + LW'(1);
              end
            end else begin
              bad_cnt_d = '0;
              emit      = 1'b1;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase

      if (emit) begin
        valid_d   = (word_cls == W_DATA);
        msg_end_d = (word_cls == W_END);
        if (word_cls == W_DATA) begin
          i_d = sr_q[29:17];
          q_d = sr_q[13:1];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_clk_meta_q  <= 1'b0;
      rx_clk_sync_q  <= 1'b0;
      rx_clk_dly_q   <= 1'b0;
      rx_data_meta_q <= 1'b0;
      rx_data_sync_q <= 1'b0;
      bit_edge_q     <= 1'b0;
      sr_q           <= '0;
      bit_cnt_q      <= '0;
      state_q        <= ST_HUNT;
      good_cnt_q     <= '0;
      bad_cnt_q      <= '0;
      i_q            <= '0;
      q_q            <= '0;
      valid_q        <= 1'b0;
      msg_end_q      <= 1'b0;
      locked_q       <= 1'b0;
    end else begin
      rx_clk_meta_q  <= rx_clk_meta_d;
      rx_clk_sync_q  <= rx_clk_sync_d;
      rx_clk_dly_q   <= rx_clk_dly_d;
      rx_data_meta_q <= rx_data_meta_d;
      rx_data_sync_q <= rx_data_sync_d;
      bit_edge_q     <= bit_edge_d;
      sr_q           <= sr_d;
      bit_cnt_q      <= bit_cnt_d;
      state_q        <= state_d;
      good_cnt_q     <= good_cnt_d;
      bad_cnt_q      <= bad_cnt_d;
      i_q            <= i_d;
      q_q            <= q_d;
      valid_q        <= valid_d;
      msg_end_q      <= msg_end_d;
      locked_q       <= locked_d;
    end
  end

`ifdef IQ_FRAME_RX_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (bit_edge_q && state_q == ST_LOCKED && word_wrap && word_cls == W_BAD &&
        err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) err_cnt_q <= '0;
    else          err_cnt_q <= err_cnt_d;
  end

  assign frame_err_cnt = err_cnt_q;
`else
  assign frame_err_cnt = 8'd0;
`endif

  assign i_data  = i_q;
  assign q_data  = q_q;
  assign valid   = valid_q;
  assign msg_end = msg_end_q;
  assign locked  = locked_q;

endmodule
